// File: rtl/mul_rnd_pipe_pkg.sv
// +--------------------------------------------------------------------+
// | mul_rnd_pkg : op encodings and pipeline control bundle             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mul_rnd_pkg;

   localparam logic [1:0] OP_MUL     = 2'b00;
   localparam logic [1:0] OP_MAC_ADD = 2'b01;
   localparam logic [1:0] OP_MAC_SUB = 2'b10;
   localparam logic [1:0] OP_CLR     = 2'b11;

   typedef struct packed {
      logic [1:0] op;
      logic       otype;
      logic       ibf;
      logic       rnd;
      logic       sat;
      logic       shovf;
   } ctl_t;

endpackage

`default_nettype wire

// File: rtl/mul_rnd_pipe_if.sv
// +--------------------------------------------------------------------+
// | mul_rnd_pipe_if : operation / result handshake bundle              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface mul_rnd_pipe_if #(parameter int SIZE = 16);
   logic                in_valid;
   logic                in_ready;
   logic [SIZE-1:0]     a;
   logic [SIZE-1:0]     b;
   logic [1:0]          ps_mul_op;
   logic                ps_mul_otype;
   logic                ps_mul_IbF;
   logic                ps_mul_rndPrdt;
   logic                ps_mul_sat;
   logic                out_valid;
   logic                out_ready;
   logic [2*SIZE-1:0]   out;
   logic                ovf;
   logic [2*SIZE-1:0]   mr;

   modport master (
      output in_valid, a, b, ps_mul_op, ps_mul_otype, ps_mul_IbF,
             ps_mul_rndPrdt, ps_mul_sat, out_ready,
      input  in_ready, out_valid, out, ovf, mr
   );

   modport slave (
      input  in_valid, a, b, ps_mul_op, ps_mul_otype, ps_mul_IbF,
             ps_mul_rndPrdt, ps_mul_sat, out_ready,
      output in_ready, out_valid, out, ovf, mr
   );
endinterface

`default_nettype wire

// File: rtl/mul_rnd_pipe_rnd_sat.sv
// +--------------------------------------------------------------------+
// | rnd_sat : round-half-even on the exact result, then range/clamp    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rnd_sat #(
   parameter int SIZE = 16
) (
   input  logic [2*SIZE+1:0] r_i,
   input  logic              otype_i,
   input  logic              rnd_i,
   input  logic              sat_i,
   output logic [2*SIZE-1:0] res_o,
   output logic              ovf_o
);

   localparam int W  = 2*SIZE;
   localparam int WX = 2*SIZE+2;

   logic [WX-1:0] rounded;
   logic          inc;
   logic [2:0]    top;

   // r_i is the exact (unwrapped) result, so the range test also catches rounding carries
   always_comb begin
      inc     = r_i[SIZE-1] & (r_i[SIZE] | (|r_i[SIZE-2:0]));
      rounded = r_i;
      if (rnd_i)
         rounded = {r_i[WX-1:SIZE] + {{(WX-SIZE-1){1'b0}}, inc}, {SIZE{1'b0}}};
      top = rounded[WX-1:W-1];
      if (otype_i)
         ovf_o = ~((&top) | ~(|top));
      else
         ovf_o = |rounded[WX-1:W];
      res_o = rounded[W-1:0];
      if (ovf_o && sat_i) begin
         if (otype_i)
            res_o = rounded[WX-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
         else
            res_o = rounded[WX-1] ? {W{1'b0}} : {W{1'b1}};
      end
   end

endmodule

`default_nettype wire

// File: rtl/mul_rnd_pipe.sv
// +--------------------------------------------------------------------+
// | mul_rnd_pipe : 3-stage multiply/MAC with round-even and saturation |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mul_rnd_pipe
   import mul_rnd_pkg::*;
#(
   parameter int SIZE = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   mul_rnd_pipe_if.slave  bus
);

   localparam int W  = 2*SIZE;
   localparam int WX = 2*SIZE+2;
   localparam logic [SIZE-1:0] MOST_NEG = {1'b1, {(SIZE-1){1'b0}}};

   logic            en;
   logic            v1_q, v2_q, out_valid_q, ovf_q;
   logic [SIZE-1:0] a1_q, b1_q;
   ctl_t            c1_q, c2_q, c2_d;
   logic [W-1:0]    a_x, b_x, prod, p2_d, p2_q;
   logic [W-1:0]    out_q, mr_q, res_d;
   logic [WX-1:0]   mr_x, p_x, acc_d;
   logic            ovf_d;

   assign en           = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = en;

   // S1: operand and control capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
      end else if (en) begin
         v1_q <= bus.in_valid;
      end
      if (en) begin
         a1_q <= bus.a;
         b1_q <= bus.b;
         c1_q <= '{op: bus.ps_mul_op, otype: bus.ps_mul_otype, ibf: bus.ps_mul_IbF,
                   rnd: bus.ps_mul_rndPrdt, sat: bus.ps_mul_sat, shovf: 1'b0};
      end
   end

   // S2: low 2*SIZE bits of the product are identical for signed and unsigned once extended
   always_comb begin
      a_x  = c1_q.otype ? {{SIZE{a1_q[SIZE-1]}}, a1_q} : {{SIZE{1'b0}}, a1_q};
      b_x  = c1_q.otype ? {{SIZE{b1_q[SIZE-1]}}, b1_q} : {{SIZE{1'b0}}, b1_q};
      prod = a_x * b_x;
      p2_d = prod;
      c2_d = c1_q;
      if (c1_q.ibf && c1_q.otype) begin
         p2_d       = prod << 1;
         c2_d.shovf = (a1_q == MOST_NEG) && (b1_q == MOST_NEG);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2_q <= 1'b0;
      end else if (en) begin
         v2_q <= v1_q;
      end
      if (en) begin
         p2_q <= p2_d;
         c2_q <= c2_d;
      end
   end

   // S3: exact accumulate in two guard bits; the shifted -1*-1 product is taken as +1.0
   always_comb begin
      mr_x = c2_q.otype ? {{2{mr_q[W-1]}}, mr_q} : {2'b00, mr_q};
      p_x  = (c2_q.otype && !c2_q.shovf) ? {{2{p2_q[W-1]}}, p2_q} : {2'b00, p2_q};
      case (c2_q.op)
         OP_MUL:     acc_d = p_x;
         OP_MAC_ADD: acc_d = mr_x + p_x;
         OP_MAC_SUB: acc_d = mr_x - p_x;
         default:    acc_d = '0;
      endcase
   end

   rnd_sat #(.SIZE(SIZE)) u_rnd_sat (
      .r_i     (acc_d),
      .otype_i (c2_q.otype),
      .rnd_i   (c2_q.ibf & c2_q.rnd),
      .sat_i   (c2_q.sat),
      .res_o   (res_d),
      .ovf_o   (ovf_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         ovf_q       <= 1'b0;
         mr_q        <= '0;
      end else if (en) begin
         out_valid_q <= v2_q;
         if (v2_q) begin
            out_q <= res_d;
            ovf_q <= ovf_d;
            mr_q  <= res_d;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out       = out_q;
   assign bus.ovf       = ovf_q;
   assign bus.mr        = mr_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_rnd_pipe.sv
// +--------------------------------------------------------------------+
// | tb_mul_rnd_pipe : directed + randomized bench with integer model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mul_rnd_pipe;
   import mul_rnd_pkg::*;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        ot, ibf, rnd, sat;
   } op_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mul_rnd_pipe_if #(.SIZE(16)) bus ();
   mul_rnd_pipe #(.SIZE(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m_mr  = '0;
   logic [31:0] exp_out[$], got_out[$];
   logic        exp_ovf[$], got_ovf[$];
   op_t         stim[$];

   function automatic op_t mk(logic [1:0] op, logic [15:0] a, logic [15:0] b,
                              logic ot, logic ibf, logic rnd, logic sat);
      op_t o;
      o.op = op; o.a = a; o.b = b; o.ot = ot; o.ibf = ibf; o.rnd = rnd; o.sat = sat;
      return o;
   endfunction

   // Exact arithmetic on the real values, then round-half-even, range check, clamp
   function automatic void model_push(op_t o);
      longint av, bv, p, m, acc, q, r, lo, hi;
      logic [31:0] res;
      bit ov;
      av = o.ot ? longint'($signed(o.a)) : longint'(o.a);
      bv = o.ot ? longint'($signed(o.b)) : longint'(o.b);
      p  = av * bv;
      if (o.ibf && o.ot) p = p * 2;
      m  = o.ot ? longint'($signed(m_mr)) : longint'(m_mr);
      case (o.op)
         OP_MUL:     acc = p;
         OP_MAC_ADD: acc = m + p;
         OP_MAC_SUB: acc = m - p;
         default:    acc = 0;
      endcase
      if (o.ibf && o.rnd) begin
         q = acc >>> 16;
         r = acc - q * 65536;
         if (r > 32768 || (r == 32768 && q[0])) q = q + 1;
         acc = q * 65536;
      end
      lo  = o.ot ? -(longint'(1) <<< 31) : 0;
      hi  = o.ot ? (longint'(1) <<< 31) - 1 : (longint'(1) <<< 32) - 1;
      ov  = (acc < lo) || (acc > hi);
      res = acc[31:0];
      if (ov && o.sat) res = (acc < lo) ? lo[31:0] : hi[31:0];
      m_mr = res;
      exp_out.push_back(res);
      exp_ovf.push_back(ov);
   endfunction

   task automatic set_op(op_t o);
      bus.ps_mul_op = o.op; bus.a = o.a; bus.b = o.b;
      bus.ps_mul_otype = o.ot; bus.ps_mul_IbF = o.ibf;
      bus.ps_mul_rndPrdt = o.rnd; bus.ps_mul_sat = o.sat;
   endtask

   task automatic clear_q();
      exp_out.delete(); exp_ovf.delete(); got_out.delete(); got_ovf.delete();
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge
   task automatic send(op_t o);
      int g = 0;
      set_op(o);
      bus.in_valid = 1'b1;
      #2;
      while (!bus.in_ready && g < 300) begin
         @(negedge clk); #2; g++;
      end
      if (!bus.in_ready) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
      end else begin
         model_push(o);
      end
      @(negedge clk);
   endtask

   task automatic drive_and_capture(int nexp, bit rand_rdy);
      fork
         begin
            foreach (stim[i]) send(stim[i]);
            bus.in_valid = 1'b0;
         end
         begin
            int cyc = 0;
            while (got_out.size() < nexp && cyc < 3000) begin
               @(negedge clk);
               bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
               #2;
               if (bus.out_valid && bus.out_ready) begin
                  got_out.push_back(bus.out);
                  got_ovf.push_back(bus.ovf);
               end
               cyc++;
            end
            bus.out_ready = 1'b1;
         end
      join
      stim.delete();
   endtask

   function automatic logic [15:0] rand16();
      case ($urandom_range(0, 5))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'hFFFF;
         3:       return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
      n_cmp++; if (bus.out !== 32'h0) begin n_err++; $display("FAIL rst_out: got %h required 0", bus.out); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b required 0", bus.ovf); end
      n_cmp++; if (bus.mr !== 32'h0) begin n_err++; $display("FAIL rst_mr: got %h required 0", bus.mr); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      m_mr  = '0;
   endtask

   task automatic test_frac_latency();
      int lat;
      @(negedge clk);
      clear_q();
      send(mk(OP_MUL, 16'h4000, 16'h4000, 1, 1, 0, 0));
      bus.in_valid = 1'b0;
      #2;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk); #2; lat++;
      end
      n_cmp++; if (lat != 3) begin n_err++; $display("FAIL frac_latency: got %0d cycles required 3", lat); end
      n_cmp++; if (bus.out !== exp_out[0] || bus.ovf !== exp_ovf[0]) begin
         n_err++; $display("FAIL frac_basic: out=%h ovf=%b required out=%h ovf=%b", bus.out, bus.ovf, exp_out[0], exp_ovf[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_directed(string name, int n, bit chk_mr);
      drive_and_capture(n, 1'b0);
      n_cmp++; if (got_out.size() != exp_out.size()) begin
         n_err++; $display("FAIL %s_count: got %0d results required %0d", name, got_out.size(), exp_out.size());
      end
      for (int i = 0; i < got_out.size() && i < exp_out.size(); i++) begin
         n_cmp++;
         if (got_out[i] !== exp_out[i] || got_ovf[i] !== exp_ovf[i]) begin
            n_err++; $display("FAIL %s[%0d]: out=%h ovf=%b required out=%h ovf=%b", name, i, got_out[i], got_ovf[i], exp_out[i], exp_ovf[i]);
         end
      end
      if (chk_mr) begin
         n_cmp++; if (bus.mr !== m_mr) begin n_err++; $display("FAIL %s_mr: got %h required %h", name, bus.mr, m_mr); end
      end
      @(negedge clk);
   endtask

   task automatic test_round_ties();
      @(negedge clk);
      clear_q();
      stim.push_back(mk(OP_MUL, 16'h0001, 16'h4000, 1, 1, 1, 0));
      stim.push_back(mk(OP_MUL, 16'h0003, 16'h4000, 1, 1, 1, 0));
      stim.push_back(mk(OP_MUL, 16'h0003, 16'h4400, 1, 1, 1, 0));
      test_directed("round_tie", 3, 1'b0);
   endtask

   task automatic test_most_neg();
      @(negedge clk);
      clear_q();
      stim.push_back(mk(OP_MUL, 16'h8000, 16'h8000, 1, 1, 0, 1));
      stim.push_back(mk(OP_MUL, 16'h8000, 16'h8000, 1, 1, 0, 0));
      test_directed("most_neg", 2, 1'b0);
   endtask

   task automatic test_mac_chain();
      @(negedge clk);
      clear_q();
      stim.push_back(mk(OP_CLR, 16'h0000, 16'h0000, 1, 0, 0, 1));
      repeat (3) stim.push_back(mk(OP_MAC_ADD, 16'h7FFF, 16'h7FFF, 1, 0, 0, 1));
      stim.push_back(mk(OP_MAC_SUB, 16'h7FFF, 16'h0003, 1, 0, 0, 1));
      test_directed("mac_chain", 5, 1'b1);
   endtask

   task automatic test_backpressure();
      int   k = 0;
      logic [31:0] held = '0;
      op_t  o;
      @(negedge clk);
      clear_q();
      bus.out_ready = 1'b0;
      o = mk(OP_MUL, 16'h0001, 16'h0002, 0, 0, 0, 0);
      for (int c = 0; c < 8; c++) begin
         if (k < 5) begin
            o.a = 16'(k + 1); set_op(o); bus.in_valid = 1'b1;
         end
         #2;
         if (k < 5 && bus.in_ready) begin model_push(o); k++; end
         if (c == 4) held = bus.out;
         @(negedge clk);
      end
      #2;
      n_cmp++; if (k != 3) begin n_err++; $display("FAIL bp_accepts: got %0d required 3", k); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b required 0", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out !== held || bus.out !== exp_out[0]) begin
         n_err++; $display("FAIL bp_hold: valid=%b out=%h earlier=%h required %h", bus.out_valid, bus.out, held, exp_out[0]);
      end
      @(negedge clk);
      for (int i = k; i < 5; i++) stim.push_back(mk(OP_MUL, 16'(i + 1), 16'h0002, 0, 0, 0, 0));
      test_directed("backpressure", 5, 1'b0);
   endtask

   task automatic test_reset_midop();
      bit seen = 1'b0;
      @(negedge clk);
      clear_q();
      send(mk(OP_MAC_ADD, 16'h0003, 16'h0005, 1, 0, 0, 0));
      send(mk(OP_MAC_ADD, 16'h0007, 16'h0009, 1, 0, 0, 0));
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.mr !== 32'h0 || bus.ovf !== 1'b0) begin
         n_err++; $display("FAIL midop_reset: valid=%b mr=%h ovf=%b required 0/0/0", bus.out_valid, bus.mr, bus.ovf);
      end
      m_mr = '0;
      repeat (6) begin
         @(negedge clk); #2;
         if (bus.out_valid) seen = 1'b1;
      end
      n_cmp++; if (seen) begin n_err++; $display("FAIL midop_stale: stale out_valid=1 seen, required none"); end
      clear_q();
   endtask

   task automatic test_random();
      @(negedge clk);
      clear_q();
      for (int i = 0; i < 120; i++)
         stim.push_back(mk(2'($urandom_range(0, 3)), rand16(), rand16(),
                           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
      drive_and_capture(120, 1'b1);
      n_cmp++; if (got_out.size() != exp_out.size()) begin
         n_err++; $display("FAIL random_count: got %0d results required %0d", got_out.size(), exp_out.size());
      end
      for (int i = 0; i < got_out.size() && i < exp_out.size(); i++) begin
         n_cmp++;
         if (got_out[i] !== exp_out[i] || got_ovf[i] !== exp_ovf[i]) begin
            n_err++; $display("FAIL random[%0d]: out=%h ovf=%b required out=%h ovf=%b", i, got_out[i], got_ovf[i], exp_out[i], exp_ovf[i]);
         end
      end
      n_cmp++; if (bus.mr !== m_mr) begin n_err++; $display("FAIL random_mr: got %h required %h", bus.mr, m_mr); end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      set_op(mk(OP_MUL, 16'h0, 16'h0, 0, 0, 0, 0));
      test_reset();
      test_frac_latency();
      test_round_ties();
      test_most_neg();
      test_mac_chain();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
